// File: rtl/id_pkg.sv
// Shared constants and decode helpers for the instruction-decode stage.
package id_pkg;

  // Default widths; the modules take these as parameter defaults.
  localparam int unsigned DATA_W_DFLT  = 64;
  localparam int unsigned REG_AW_DFLT  = 5;
  localparam int unsigned INSTR_W_DFLT = 32;
  localparam int unsigned CNT_W_DFLT   = 16;

  // Opcode encodings; 100-111 are illegal and decode as NOP.
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_MOV   = 3'b011;

  // Instruction field positions.
  localparam int unsigned OP_LSB   = 29;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned RD_LSB   = 24;
  localparam int unsigned RS1_LSB  = 19;
  localparam int unsigned RS2_LSB  = 14;
  localparam int unsigned FIELD_W  = 5;
  localparam int unsigned RSVD_W   = 14;

  // Static properties of an opcode.
  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wreg_en;
    logic wmem_en;
  } dec_t;

  function automatic dec_t decode_op(input logic [OP_W-1:0] op);
    dec_t d;
    d = '0;
    unique case (op)
      OP_LOAD: begin
        d.use_rs1 = 1'b1;
        d.wreg_en = 1'b1;
      end
      OP_STORE: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.wmem_en = 1'b1;
      end
      OP_MOV: begin
        d.use_rs1 = 1'b1;
        d.wreg_en = 1'b1;
      end
      default: d = '0;  // NOP and illegal opcodes
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two async read ports, one write port, r0 hardwired to zero,
// synchronous clear, and write-through bypass from the write port.
module regfile_2r1w
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned REG_AW = REG_AW_DFLT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [NumRegs];
  logic [DATA_W-1:0] mem_d [NumRegs];
  logic              wr_ok;

  // Writes to r0 are dropped so it keeps reading zero.
  assign wr_ok = we_i && (waddr_i != '0);

  // Next-state of the array: clear on reset, else a single-entry write.
  always_comb begin
    mem_d = mem_q;
    if (RST) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_ok) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Array storage.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Read ports with r0 tie-off and same-cycle bypass of the writeback value.
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
    if (wr_ok && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (wr_ok && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes Instr_in, reads operands, detects RAW
// hazards against EX/MEM, injects bubbles and counts stall cycles.
module id_stage
  import id_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned REG_AW  = REG_AW_DFLT,
  parameter int unsigned INSTR_W = INSTR_W_DFLT,
  parameter int unsigned CNT_W   = CNT_W_DFLT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [INSTR_W-1:0] Instr_in,
  input  logic               Instr_valid,
  input  logic               ex_WRegEn,
  input  logic [REG_AW-1:0]  ex_WReg1,
  input  logic               mem_WRegEn,
  input  logic [REG_AW-1:0]  mem_WReg1,
  input  logic               WB_WRegEn,
  input  logic [REG_AW-1:0]  WB_WReg1,
  input  logic [DATA_W-1:0]  WB_WData,
  output logic               WRegEn_out,
  output logic               WMemEn_out,
  output logic [DATA_W-1:0]  R1out,
  output logic [DATA_W-1:0]  R2out,
  output logic [REG_AW-1:0]  WReg1_out,
  output logic               Stall,
  output logic [CNT_W-1:0]   StallCnt
);

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [RSVD_W-1:0] unused_rsvd;
  dec_t              dec;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              rs1_hz;
  logic              rs2_hz;
  logic              hz;
  logic              issue;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  // Field extraction; the reserved low bits are deliberately ignored.
  always_comb begin
    op          = Instr_in[OP_LSB +: OP_W];
    rd          = Instr_in[RD_LSB +: REG_AW];
    rs1         = Instr_in[RS1_LSB +: REG_AW];
    rs2         = Instr_in[RS2_LSB +: REG_AW];
    unused_rsvd = Instr_in[RSVD_W-1:0];
    dec         = decode_op(op);
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .CLK      (CLK),
    .RST      (RST),
    .we_i     (WB_WRegEn),
    .waddr_i  (WB_WReg1),
    .wdata_i  (WB_WData),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // RAW hazard: only operands the opcode actually reads, and never on r0.
  // WB-stage producers are covered by the regfile bypass, not stalled.
  always_comb begin
    rs1_hz = dec.use_rs1 && (rs1 != '0) &&
             ((ex_WRegEn && (rs1 == ex_WReg1)) || (mem_WRegEn && (rs1 == mem_WReg1)));
    rs2_hz = dec.use_rs2 && (rs2 != '0) &&
             ((ex_WRegEn && (rs2 == ex_WReg1)) || (mem_WRegEn && (rs2 == mem_WReg1)));
    hz     = Instr_valid && (rs1_hz || rs2_hz);
    issue  = Instr_valid && !hz;
  end

  // ID/EX inputs: bubble on hazard or invalid slot, everything zero in reset.
  always_comb begin
    WRegEn_out = 1'b0;
    WMemEn_out = 1'b0;
    WReg1_out  = '0;
    R1out      = '0;
    R2out      = '0;
    Stall      = 1'b0;
    if (!RST) begin
      Stall = hz;
      R1out = rd1;
      R2out = rd2;
      if (issue) begin
        WRegEn_out = dec.wreg_en;
        WMemEn_out = dec.wmem_en;
        WReg1_out  = dec.wreg_en ? rd : '0;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (RST) begin
      stall_cnt_d = '0;
    end else if (hz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random stimulus,
// all compared against a behavioural model of the decode stage.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Instr_in;
  logic        Instr_valid;
  logic        ex_WRegEn;
  logic [4:0]  ex_WReg1;
  logic        mem_WRegEn;
  logic [4:0]  mem_WReg1;
  logic        WB_WRegEn;
  logic [4:0]  WB_WReg1;
  logic [63:0] WB_WData;
  logic        WRegEn_out;
  logic        WMemEn_out;
  logic [63:0] R1out;
  logic [63:0] R2out;
  logic [4:0]  WReg1_out;
  logic        Stall;
  logic [15:0] StallCnt;

  id_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .Instr_in    (Instr_in),
    .Instr_valid (Instr_valid),
    .ex_WRegEn   (ex_WRegEn),
    .ex_WReg1    (ex_WReg1),
    .mem_WRegEn  (mem_WRegEn),
    .mem_WReg1   (mem_WReg1),
    .WB_WRegEn   (WB_WRegEn),
    .WB_WReg1    (WB_WReg1),
    .WB_WData    (WB_WData),
    .WRegEn_out  (WRegEn_out),
    .WMemEn_out  (WMemEn_out),
    .R1out       (R1out),
    .R2out       (R2out),
    .WReg1_out   (WReg1_out),
    .Stall       (Stall),
    .StallCnt    (StallCnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural registers and the stall count.
  logic [63:0] ref_rf [32];
  int unsigned ref_cnt;

  // Expected values for the current cycle.
  logic        exp_hz, e_stall, e_wreg, e_wmem, chk1, chk2;
  logic [4:0]  e_rd;
  logic [63:0] e_r1, e_r2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = $urandom;  // reserved bits get noise
    w[31:29] = op[2:0];
    w[28:24] = rd[4:0];
    w[23:19] = rs1[4:0];
    w[18:14] = rs2[4:0];
    return w;
  endfunction

  // A register is "in flight" if EX or MEM is about to write it.
  function automatic logic busy(input logic [4:0] rs);
    return (rs != 0) && ((ex_WRegEn && ex_WReg1 == rs) || (mem_WRegEn && mem_WReg1 == rs));
  endfunction

  // Architectural read as seen in this cycle, including the WB value.
  function automatic logic [63:0] arch_read(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (WB_WRegEn && WB_WReg1 == a) return WB_WData;
    return ref_rf[a];
  endfunction

  task automatic predict();
    int  op;
    bit  use1, use2, writes;
    op     = int'(Instr_in[31:29]);
    use1   = (op == 1) || (op == 2) || (op == 3);
    use2   = (op == 2);
    writes = (op == 1) || (op == 3);
    exp_hz = Instr_valid && ((use1 && busy(Instr_in[23:19])) || (use2 && busy(Instr_in[18:14])));
    chk1   = RST || use1;
    chk2   = RST || use2;
    if (RST) begin
      e_stall = 0; e_wreg = 0; e_wmem = 0; e_rd = 0; e_r1 = 0; e_r2 = 0;
    end else begin
      e_stall = exp_hz;
      e_wreg  = Instr_valid && !exp_hz && writes;
      e_wmem  = Instr_valid && !exp_hz && (op == 2);
      e_rd    = e_wreg ? Instr_in[28:24] : 5'd0;
      e_r1    = arch_read(Instr_in[23:19]);
      e_r2    = arch_read(Instr_in[18:14]);
    end
  endtask

  task automatic commit();
    if (RST) begin
      for (int i = 0; i < 32; i++) ref_rf[i] = 64'd0;
      ref_cnt = 0;
    end else begin
      if (exp_hz && ref_cnt != 32'hFFFF) ref_cnt++;
      if (WB_WRegEn && WB_WReg1 != 0) ref_rf[WB_WReg1] = WB_WData;
    end
  endtask

  // One clock: compare mid-cycle, advance the model on the edge.
  task automatic step(input bit do_chk);
    @(negedge CLK);
    predict();
    if (do_chk) begin
      check("Stall", 64'(Stall), 64'(e_stall));
      check("WRegEn_out", 64'(WRegEn_out), 64'(e_wreg));
      check("WMemEn_out", 64'(WMemEn_out), 64'(e_wmem));
      check("WReg1_out", 64'(WReg1_out), 64'(e_rd));
      check("StallCnt", 64'(StallCnt), 64'(ref_cnt));
      if (chk1) check("R1out", R1out, e_r1);
      if (chk2) check("R2out", R2out, e_r2);
    end
    @(posedge CLK);
    commit();
    #1;
  endtask

  task automatic quiet();
    ex_WRegEn = 0; ex_WReg1 = 0; mem_WRegEn = 0; mem_WReg1 = 0;
    WB_WRegEn = 0; WB_WReg1 = 0; WB_WData = 0;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = 64'd0;
    ref_cnt = 0;
    RST = 1; Instr_in = 0; Instr_valid = 0;
    quiet();
    #1;
    step(0);
    step(1);
    RST = 0;

    // MOV r3 <- r0
    Instr_valid = 1;
    Instr_in = mk(3, 3, 0, 0);
    step(1);
    // STORE with rs1 bypassed from a same-cycle WB write of r5
    WB_WRegEn = 1; WB_WReg1 = 5; WB_WData = 64'h1234;
    Instr_in = mk(2, 6, 5, 0);
    step(1);
    quiet();
    // LOAD r7 producer walks EX -> MEM -> WB
    Instr_in = mk(1, 2, 7, 0);
    ex_WRegEn = 1; ex_WReg1 = 7;
    step(1);
    quiet(); mem_WRegEn = 1; mem_WReg1 = 7;
    step(1);
    quiet();
    step(1);
    check("StallCnt after two stalls", 64'(StallCnt), 64'd2);
    // STORE rs2 hit in MEM; MOV ignores its rs2 field; r0 never hazards
    Instr_in = mk(2, 0, 1, 9); mem_WRegEn = 1; mem_WReg1 = 9;
    step(1);
    quiet(); Instr_in = mk(3, 1, 4, 9); ex_WRegEn = 1; ex_WReg1 = 9;
    step(1);
    quiet(); Instr_in = mk(3, 1, 0, 0); ex_WRegEn = 1; ex_WReg1 = 0;
    step(1);
    // Writes to r0 are dropped; illegal opcode decodes as NOP
    quiet(); WB_WRegEn = 1; WB_WReg1 = 0; WB_WData = 64'hFFFF;
    Instr_in = mk(3, 2, 0, 0);
    step(1);
    quiet();
    step(1);
    Instr_in = mk(6, 9, 5, 5);
    step(1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      RST         = ($urandom_range(0, 63) == 0);
      Instr_valid = ($urandom_range(0, 7) != 0);
      Instr_in    = mk($urandom_range(0, 7), rnd_reg(), rnd_reg(), rnd_reg());
      ex_WRegEn   = $urandom_range(0, 1) == 1;
      ex_WReg1    = rnd_reg();
      mem_WRegEn  = $urandom_range(0, 1) == 1;
      mem_WReg1   = rnd_reg();
      WB_WRegEn   = $urandom_range(0, 1) == 1;
      WB_WReg1    = rnd_reg();
      WB_WData    = {$urandom, $urandom};
      step(1);
    end

    // Hold a hazard long enough to saturate the counter
    RST = 0; quiet(); Instr_valid = 1;
    Instr_in = mk(1, 2, 1, 0); ex_WRegEn = 1; ex_WReg1 = 1;
    for (int i = 0; i < 65540; i++) begin
      step((i % 1024 == 0) || (i > 65530));
    end
    step(1);
    check("StallCnt saturated", 64'(StallCnt), 64'hFFFF);

    // Reset in the middle of the stall
    RST = 1;
    step(1);
    step(1);
    check("StallCnt after reset", 64'(StallCnt), 64'd0);
    RST = 0; quiet();
    for (int r = 1; r < 32; r++) begin
      Instr_in = mk(3, 0, r, 0);
      step(1);
      check("reg cleared", R1out, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
